// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmitter with a small byte FIFO
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] character,
    input  logic       sendValid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       txDone
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]    COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    state_t            state;
    state_t            state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_next;
    logic [2:0]        bit_index;
    logic [2:0]        bit_next;
    logic [7:0]        shift;
    logic [7:0]        shift_next;
    logic              tx_q;
    logic              tx_next;

    logic              push;
    logic              pop;

    // A full FIFO refuses new bytes even if a pop happens on the same edge.
    assign ready = (count != COUNT_FULL);
    assign push  = sendValid && ready;
    assign busy  = (state != IDLE) || (count != '0);
    assign tx    = tx_q;

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= character;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame sequencer registers; reset drops the line high and abandons any partial frame.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_index <= '0;
            shift     <= '0;
            tx_q      <= 1'b1;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_index <= bit_next;
            shift     <= shift_next;
            tx_q      <= tx_next;
        end
    end

    // Next-state logic: tx is computed one edge ahead so the line itself is registered.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_index;
        shift_next = shift;
        tx_next    = tx_q;
        pop        = 1'b0;
        txDone     = 1'b0;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (count != '0) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    tx_next    = 1'b0;
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_next  = '0;
                    tx_next    = shift[0];
                    bit_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_next = '0;
                    if (bit_index == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        shift_next = {1'b0, shift[7:1]};
                        tx_next    = shift[1];
                        bit_next   = bit_index + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    txDone    = 1'b1;
                    baud_next = '0;
                    // Chain straight into the next start bit when a byte is waiting.
                    if (count != '0) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        tx_next    = 1'b0;
                        state_next = START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - directed self-checking bench for uart_transmitter
module tb_uart_transmitter;

    logic       clock;
    logic       resetn_a, resetn_b;
    logic [7:0] character_a, character_b;
    logic       sendValid_a, sendValid_b;
    logic       ready_a, ready_b;
    logic       tx_a, tx_b;
    logic       busy_a, busy_b;
    logic       txDone_a, txDone_b;

    int checks = 0;
    int errors = 0;
    int rst_cnt_a = 0;
    int rst_cnt_b = 0;
    int done_a = 0;
    int done_b = 0;
    logic [7:0] rx_a_q[$];
    logic [7:0] rx_b_q[$];
    logic       stop_a_q[$];
    logic       stop_b_q[$];

    uart_transmitter #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut_a (
        .clock(clock), .resetn(resetn_a), .character(character_a), .sendValid(sendValid_a),
        .ready(ready_a), .tx(tx_a), .busy(busy_a), .txDone(txDone_a)
    );

    uart_transmitter #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut_b (
        .clock(clock), .resetn(resetn_b), .character(character_b), .sendValid(sendValid_b),
        .ready(ready_b), .tx(tx_b), .busy(busy_b), .txDone(txDone_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        if (resetn_a === 1'b0) rst_cnt_a <= rst_cnt_a + 1;
        if (resetn_b === 1'b0) rst_cnt_b <= rst_cnt_b + 1;
    end

    always @(negedge clock) begin
        if (txDone_a === 1'b1) done_a <= done_a + 1;
        if (txDone_b === 1'b1) done_b <= done_b + 1;
    end

    // Serial sampler: detects a falling edge, samples each bit mid-period, aborts on reset.
    task automatic decode(input bit sel);
        int         c;
        int         rc;
        logic       prev;
        logic       cur;
        logic [9:0] frame;
        bit         aborted;
        c    = sel ? 16 : 4;
        prev = 1'b1;
        forever begin
            @(negedge clock);
            cur = sel ? tx_b : tx_a;
            if (prev === 1'b1 && cur === 1'b0) begin
                rc      = sel ? rst_cnt_b : rst_cnt_a;
                aborted = 1'b0;
                frame   = '0;
                for (int cyc = 1; cyc <= 9 * c + c / 2 + 1; cyc++) begin
                    if (cyc > 1) @(negedge clock);
                    cur = sel ? tx_b : tx_a;
                    if ((sel ? rst_cnt_b : rst_cnt_a) != rc) begin
                        aborted = 1'b1;
                        break;
                    end
                    if ((cyc - 1) % c == c / 2) frame[(cyc - 1) / c] = cur;
                end
                if (!aborted) begin
                    if (sel) begin
                        rx_b_q.push_back(frame[8:1]);
                        stop_b_q.push_back(frame[9]);
                    end else begin
                        rx_a_q.push_back(frame[8:1]);
                        stop_a_q.push_back(frame[9]);
                    end
                end
            end
            prev = cur;
        end
    endtask

    initial decode(1'b0);
    initial decode(1'b1);

    // Cycle-exact check of one frame on dut_a; caller stands one negedge before frame cycle 1.
    task automatic check_frame(input logic [7:0] d, input string name);
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            sendValid_a = 1'b0;
            checks++;
            if (tx_a !== f[(n - 1) / 4]) begin
                errors++;
                $display("FAIL %s_tx cycle %0d: got %b expected %b", name, n, tx_a, f[(n - 1) / 4]);
            end
            checks++;
            if (txDone_a !== 1'(n == 40)) begin
                errors++;
                $display("FAIL %s_txdone cycle %0d: got %b expected %b", name, n, txDone_a, n == 40);
            end
            checks++;
            if (busy_a !== 1'b1) begin
                errors++;
                $display("FAIL %s_busy cycle %0d: got %b expected 1", name, n, busy_a);
            end
        end
    endtask

    task automatic test_reset();
        resetn_a = 1'b0; resetn_b = 1'b0;
        sendValid_a = 1'b0; sendValid_b = 1'b0;
        character_a = 8'h00; character_b = 8'h00;
        repeat (3) @(negedge clock);
        checks++;
        if ({tx_a, ready_a, busy_a, txDone_a} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_a: got tx/ready/busy/done=%b expected 1100", {tx_a, ready_a, busy_a, txDone_a});
        end
        checks++;
        if ({tx_b, ready_b, busy_b, txDone_b} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_b: got tx/ready/busy/done=%b expected 1100", {tx_b, ready_b, busy_b, txDone_b});
        end
        resetn_a = 1'b1; resetn_b = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({tx_a, ready_a, busy_a, txDone_a} !== 4'b1100) begin
            errors++;
            $display("FAIL idle_a: got tx/ready/busy/done=%b expected 1100", {tx_a, ready_a, busy_a, txDone_a});
        end
    endtask

    task automatic test_single();
        int base;
        rx_a_q.delete(); stop_a_q.delete();
        base = done_a;
        character_a = 8'h55; sendValid_a = 1'b1;
        @(negedge clock);
        sendValid_a = 1'b0;
        checks++;
        if (tx_a !== 1'b1 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: got tx=%b busy=%b expected tx=1 busy=1", tx_a, busy_a);
        end
        check_frame(8'h55, "single");
        @(negedge clock);
        checks++;
        if ({tx_a, busy_a, txDone_a} !== 3'b100) begin
            errors++;
            $display("FAIL single_after: got tx/busy/done=%b expected 100", {tx_a, busy_a, txDone_a});
        end
        checks++;
        if (rx_a_q.size() != 1 || rx_a_q[0] !== 8'h55 || stop_a_q[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_decode: got %0d bytes first %h expected 1 byte 55", rx_a_q.size(),
                     rx_a_q.size() > 0 ? rx_a_q[0] : 8'hxx);
        end
        checks++;
        if (done_a - base != 1) begin
            errors++;
            $display("FAIL single_done_count: got %0d expected 1", done_a - base);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        rx_a_q.delete(); stop_a_q.delete();
        base = done_a;
        repeat (2) @(negedge clock);
        character_a = 8'h00; sendValid_a = 1'b1;
        @(negedge clock);
        checks++;
        if (tx_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept_tx: got %b expected 1", tx_a);
        end
        character_a = 8'hFF;
        check_frame(8'h00, "b2b_first");
        check_frame(8'hFF, "b2b_second");
        @(negedge clock);
        checks++;
        if ({tx_a, busy_a, txDone_a} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_after: got tx/busy/done=%b expected 100", {tx_a, busy_a, txDone_a});
        end
        checks++;
        if (done_a - base != 2) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d expected 2", done_a - base);
        end
    endtask

    task automatic test_overflow();
        int waited;
        rx_a_q.delete(); stop_a_q.delete();
        repeat (2) @(negedge clock);
        for (int i = 1; i <= 8; i++) begin
            character_a = 8'(i); sendValid_a = 1'b1;
            checks++;
            if (ready_a !== 1'(i <= 5)) begin
                errors++;
                $display("FAIL overflow_ready at byte %0d: got %b expected %b", i, ready_a, i <= 5);
            end
            @(negedge clock);
        end
        sendValid_a = 1'b0;
        waited = 0;
        while (busy_a !== 1'b0 && waited < 400) begin
            @(negedge clock);
            waited++;
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL overflow_timeout: busy got %b expected 0", busy_a);
        end
        checks++;
        if (rx_a_q.size() != 5) begin
            errors++;
            $display("FAIL overflow_count: got %0d bytes expected 5", rx_a_q.size());
        end
        for (int i = 0; i < rx_a_q.size() && i < 5; i++) begin
            checks++;
            if (rx_a_q[i] !== 8'(i + 1)) begin
                errors++;
                $display("FAIL overflow_byte %0d: got %h expected %h", i, rx_a_q[i], 8'(i + 1));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int  base;
        bit  line_ok;
        rx_a_q.delete(); stop_a_q.delete();
        repeat (2) @(negedge clock);
        character_a = 8'hA3; sendValid_a = 1'b1;
        @(negedge clock);
        character_a = 8'h5A;
        @(negedge clock);
        sendValid_a = 1'b0;
        repeat (17) @(negedge clock);
        checks++;
        if (tx_a !== 1'b0) begin
            errors++;
            $display("FAIL midreset_bit3: got %b expected 0", tx_a);
        end
        resetn_a = 1'b0;
        @(negedge clock);
        resetn_a = 1'b1;
        checks++;
        if ({tx_a, busy_a, ready_a, txDone_a} !== 4'b1010) begin
            errors++;
            $display("FAIL midreset_after: got tx/busy/ready/done=%b expected 1010", {tx_a, busy_a, ready_a, txDone_a});
        end
        base = done_a;
        line_ok = 1'b1;
        repeat (100) begin
            @(negedge clock);
            if (tx_a !== 1'b1 || txDone_a !== 1'b0 || busy_a !== 1'b0) line_ok = 1'b0;
        end
        checks++;
        if (!line_ok) begin
            errors++;
            $display("FAIL midreset_quiet: got activity after reset expected idle line");
        end
        checks++;
        if (done_a != base || rx_a_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_frames: got %0d done %0d bytes expected 0 0", done_a - base, rx_a_q.size());
        end
    endtask

    task automatic test_wrap();
        int         waited;
        logic [7:0] exp_bytes [5];
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        rx_a_q.delete(); stop_a_q.delete();
        character_a = 8'h11; sendValid_a = 1'b1;
        @(negedge clock);
        character_a = 8'h22;
        @(negedge clock);
        character_a = 8'h33;
        @(negedge clock);
        sendValid_a = 1'b0;
        waited = 0;
        while (txDone_a !== 1'b1 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        checks++;
        if (txDone_a !== 1'b1 || dut_a.count !== 3'd2) begin
            errors++;
            $display("FAIL wrap_pre: got done=%b count=%0d expected done=1 count=2", txDone_a, dut_a.count);
        end
        character_a = 8'h44; sendValid_a = 1'b1;
        @(negedge clock);
        sendValid_a = 1'b0;
        checks++;
        if (dut_a.count !== 3'd2) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected 2", dut_a.count);
        end
        checks++;
        if (tx_a !== 1'b0 || ready_a !== 1'b1) begin
            errors++;
            $display("FAIL wrap_restart: got tx=%b ready=%b expected tx=0 ready=1", tx_a, ready_a);
        end
        repeat (5) @(negedge clock);
        character_a = 8'h55; sendValid_a = 1'b1;
        @(negedge clock);
        sendValid_a = 1'b0;
        waited = 0;
        while (busy_a !== 1'b0 && waited < 400) begin
            @(negedge clock);
            waited++;
        end
        checks++;
        if (rx_a_q.size() != 5) begin
            errors++;
            $display("FAIL wrap_size: got %0d bytes expected 5", rx_a_q.size());
        end
        for (int i = 0; i < rx_a_q.size() && i < 5; i++) begin
            checks++;
            if (rx_a_q[i] !== exp_bytes[i]) begin
                errors++;
                $display("FAIL wrap_order %0d: got %h expected %h", i, rx_a_q[i], exp_bytes[i]);
            end
        end
    endtask

    task automatic test_sweep();
        int base;
        int waited;
        rx_b_q.delete(); stop_b_q.delete();
        base = done_b;
        for (int v = 0; v < 256; v++) begin
            waited = 0;
            while (ready_b !== 1'b1 && waited < 400) begin
                @(negedge clock);
                waited++;
            end
            if (ready_b !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL sweep_ready at byte %0d: got %b expected 1", v, ready_b);
                break;
            end
            character_b = v[7:0]; sendValid_b = 1'b1;
            @(negedge clock);
            sendValid_b = 1'b0;
        end
        waited = 0;
        while (busy_b !== 1'b0 && waited < 2000) begin
            @(negedge clock);
            waited++;
        end
        @(negedge clock);
        checks++;
        if (rx_b_q.size() != 256) begin
            errors++;
            $display("FAIL sweep_size: got %0d bytes expected 256", rx_b_q.size());
        end
        for (int i = 0; i < rx_b_q.size(); i++) begin
            checks++;
            if (rx_b_q[i] !== 8'(i) || stop_b_q[i] !== 1'b1) begin
                errors++;
                $display("FAIL sweep_byte %0d: got %h stop %b expected %h stop 1", i, rx_b_q[i], stop_b_q[i], 8'(i));
            end
        end
        checks++;
        if (done_b - base != 256) begin
            errors++;
            $display("FAIL sweep_done_count: got %0d expected 256", done_b - base);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_wrap();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
